// File: rtl/button_event_scheduler.sv
// button_event_scheduler: shared-tick debouncer for N_BTN buttons feeding one round-robin event port.
// Define AUTOREPEAT_EN to add per-channel auto-repeat events every REPEAT_TICKS ticks while held.
module button_event_scheduler #(
   parameter int N_BTN        = 4,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_CNT   = 4,
   parameter int REPEAT_TICKS = 100
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_BTN-1:0]         btn_raw,
   output logic [N_BTN-1:0]         btn_level,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [$clog2(N_BTN)-1:0] evt_id,
   output logic                     overrun
);
   localparam int IW = $clog2(N_BTN);
   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = $clog2(STABLE_CNT + 1);

   logic [N_BTN-1:0] sync1_q, sync2_q, level_q, level_d, prev_q, pend_q, pend_d;
   logic [N_BTN-1:0] set, grant, held, busy, rpt;
   logic [PW-1:0]    presc_q, presc_d;
   logic [CW-1:0]    cnt_q [N_BTN];
   logic [CW-1:0]    cnt_d [N_BTN];
   logic [IW-1:0]    rr_q, rr_d, id_q, id_d, sel;
   logic             valid_q, valid_d, ovr_q, ovr_d, tick, found, adv;

   assign tick    = presc_q == PW'(TICK_DIV - 1);
   assign presc_d = tick ? '0 : presc_q + 1'b1;

   always_comb begin
      level_d = level_q;
      for (int i = 0; i < N_BTN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (tick) begin
            if (sync2_q[i] == level_q[i]) cnt_d[i] = '0;
            else if (cnt_q[i] == CW'(STABLE_CNT - 1)) begin
               level_d[i] = ~level_q[i];
               cnt_d[i]   = '0;
            end else cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

`ifdef AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_TICKS + 1);
   logic [RW-1:0] rep_q [N_BTN];
   logic [RW-1:0] rep_d [N_BTN];

   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         rpt[i]   = tick & level_q[i] & (rep_q[i] == RW'(REPEAT_TICKS - 1));
         rep_d[i] = (!level_q[i] || rpt[i]) ? '0 : tick ? rep_q[i] + 1'b1 : rep_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) for (int i = 0; i < N_BTN; i++) rep_q[i] <= '0;
      else rep_q <= rep_d;
   end
`else
   logic rpt_unused;
   assign rpt        = '0;
   assign rpt_unused = REPEAT_TICKS > 0;
`endif

   assign set = (level_q & ~prev_q) | rpt;

   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = N_BTN - 1; i >= 0; i--)
         if (pend_q[i]) begin
            sel   = IW'(i);
            found = 1'b1;
         end
      // lowest pending index at or above rr_q overrides the wrapped choice
      for (int i = N_BTN - 1; i >= 0; i--)
         if (pend_q[i] && IW'(i) >= rr_q) sel = IW'(i);
      adv   = !valid_q || evt_ready;
      grant = '0;
      if (adv && found) grant[sel] = 1'b1;
      valid_d = adv ? found : valid_q;
      id_d    = (adv && found) ? sel : id_q;
      rr_d    = (adv && found) ? ((sel == IW'(N_BTN - 1)) ? '0 : sel + 1'b1) : rr_q;
      // a channel still presented and not yet accepted counts as pending
      for (int i = 0; i < N_BTN; i++) held[i] = valid_q && !evt_ready && id_q == IW'(i);
      busy   = (pend_q & ~grant) | held;
      pend_d = (pend_q & ~grant) | (set & ~held);
      ovr_d  = |(set & busy);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         presc_q <= '0;
         level_q <= '0;
         prev_q  <= '0;
         pend_q  <= '0;
         rr_q    <= '0;
         id_q    <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         presc_q <= presc_d;
         level_q <= level_d;
         prev_q  <= level_q;
         pend_q  <= pend_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_level = level_q;
   assign evt_valid = valid_q;
   assign evt_id    = id_q;
   assign overrun   = ovr_q;
endmodule
